// File: rtl/pulse_generator_if.sv
// rtl/pulse_generator_if.sv - start/busy/done handshake and pulse output bundle
interface pulse_generator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] duration;
  logic             abort;
  logic             signal;
  logic             busy;
  logic             done;

  modport master (
    output start, duration, abort,
    input  signal, busy, done
  );

  modport slave (
    input  start, duration, abort,
    output signal, busy, done
  );
endinterface

// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - single programmable-width pulse with low guard time
module pulse_generator #(
  parameter int WIDTH = 16,
  parameter int GUARD = 4
) (
  input  logic               clk,
  input  logic               reset,
  pulse_generator_if.slave   bus
);
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = bus.start && (bus.duration != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    signal_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          state_d  = ST_HIGH;
          cnt_d    = bus.duration;
          signal_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_HIGH: begin
        signal_d = 1'b1;
        if (bus.abort || (cnt_q == WIDTH'(1))) begin
          signal_d = 1'b0;
          if (GUARD == 0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_GUARD;
            gcnt_d  = GUARD_INIT;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      ST_GUARD: begin
        // The guard-expiry edge doubles as an acceptance edge so a held start
        // repeats with exactly GUARD low cycles between pulses.
        if (gcnt_q == GW'(1)) begin
          done_d = 1'b1;
          if (accept) begin
            state_d  = ST_HIGH;
            cnt_d    = bus.duration;
            signal_d = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.signal = signal_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_pulse_generator.sv
// tb/tb_pulse_generator.sv - directed vector bench for pulse_generator
module tb_pulse_generator;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pulse_generator_if #(.WIDTH(16)) bus0 ();
  pulse_generator_if #(.WIDTH(16)) bus1 ();

  pulse_generator #(.WIDTH(16), .GUARD(3)) u0 (.clk(clk), .reset(rst_n), .bus(bus0));
  pulse_generator #(.WIDTH(16), .GUARD(0)) u1 (.clk(clk), .reset(rst_n), .bus(bus1));

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [15:0] duration;
    logic        abort;
    logic        sig;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic s, input logic [15:0] d, input logic a,
                      input logic es, input logic eb, input logic ed);
    vec_t v;
    v.rst_n = r; v.start = s; v.duration = d; v.abort = a;
    v.sig = es; v.busy = eb; v.done = ed;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input logic [15:0] d, input int bound);
    int hi;
    int cyc;
    bus0.start = 1'b1;
    bus0.duration = d;
    step();
    bus0.start = 1'b0;
    hi = bus0.signal ? 1 : 0;
    cyc = 0;
    while (!bus0.done && cyc < bound) begin
      step();
      if (bus0.signal) hi++;
      cyc++;
    end
    check("loop_done_seen", {31'd0, bus0.done}, 32'd1);
    check("loop_width", hi, {16'd0, d});
    step();
  endtask

  initial begin
    int seen;
    int cyc;
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.duration = '0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.duration = '0; bus1.abort = 1'b0;

    // reset held with start, then a 5-cycle pulse with an ignored mid-pulse start
    addv(0, 1, 16'd5, 0, 0, 0, 0);
    addv(0, 1, 16'd5, 0, 0, 0, 0);
    addv(1, 0, 16'd5, 0, 0, 0, 0);
    addv(1, 0, 16'd5, 0, 0, 0, 0);
    addv(1, 1, 16'd5, 0, 1, 1, 0);
    addv(1, 0, 16'd5, 0, 1, 1, 0);
    addv(1, 1, 16'd0, 0, 1, 1, 0);
    addv(1, 0, 16'd9, 0, 1, 1, 0);
    addv(1, 0, 16'd0, 0, 1, 1, 0);
    addv(1, 0, 16'd0, 0, 0, 1, 0);
    addv(1, 0, 16'd0, 0, 0, 1, 0);
    addv(1, 0, 16'd0, 0, 0, 1, 0);
    addv(1, 0, 16'd0, 0, 0, 0, 1);
    addv(1, 0, 16'd0, 0, 0, 0, 0);
    addv(1, 1, 16'd0, 0, 0, 0, 0);
    addv(1, 1, 16'd0, 0, 0, 0, 0);
    addv(1, 0, 16'd0, 1, 0, 0, 0);
    addv(1, 0, 16'd0, 0, 0, 0, 0);
    addv(1, 1, 16'd1, 0, 1, 1, 0);
    addv(1, 0, 16'd1, 0, 0, 1, 0);
    addv(1, 0, 16'd1, 1, 0, 1, 0);
    addv(1, 0, 16'd1, 0, 0, 1, 0);
    addv(1, 0, 16'd1, 0, 0, 0, 1);
    addv(1, 0, 16'd1, 0, 0, 0, 0);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      bus0.start = vq[i].start;
      bus0.duration = vq[i].duration;
      bus0.abort = vq[i].abort;
      step();
      check($sformatf("vec%0d_signal", i), {31'd0, bus0.signal}, {31'd0, vq[i].sig});
      check($sformatf("vec%0d_busy", i), {31'd0, bus0.busy}, {31'd0, vq[i].busy});
      check($sformatf("vec%0d_done", i), {31'd0, bus0.done}, {31'd0, vq[i].done});
    end
    bus0.start = 1'b0; bus0.abort = 1'b0;
    step();

    // held start, GUARD=3: period 5, done coincident with re-acceptance
    bus0.start = 1'b1; bus0.duration = 16'd2;
    for (int j = 0; j < 15; j++) begin
      step();
      check($sformatf("rep_g3_signal_%0d", j), {31'd0, bus0.signal}, ((j % 5) < 2) ? 32'd1 : 32'd0);
      check($sformatf("rep_g3_done_%0d", j), {31'd0, bus0.done}, (j >= 5 && (j % 5) == 0) ? 32'd1 : 32'd0);
      check($sformatf("rep_g3_busy_%0d", j), {31'd0, bus0.busy}, 32'd1);
    end
    bus0.start = 1'b0;
    cyc = 0;
    while (!bus0.done && cyc < 10) begin
      step();
      cyc++;
    end
    check("rep_g3_final_done", {31'd0, bus0.done}, 32'd1);
    step();

    // held start, GUARD=0: 2 high, 1 low idle/done cycle, re-accept
    bus1.start = 1'b1; bus1.duration = 16'd2;
    for (int j = 0; j < 9; j++) begin
      step();
      check($sformatf("rep_g0_signal_%0d", j), {31'd0, bus1.signal}, ((j % 3) < 2) ? 32'd1 : 32'd0);
      check($sformatf("rep_g0_busy_%0d", j), {31'd0, bus1.busy}, ((j % 3) < 2) ? 32'd1 : 32'd0);
      check($sformatf("rep_g0_done_%0d", j), {31'd0, bus1.done}, ((j % 3) == 2) ? 32'd1 : 32'd0);
    end
    bus1.start = 1'b0;
    step();
    check("rep_g0_idle_busy", {31'd0, bus1.busy}, 32'd0);

    // abort after 4 high cycles
    bus0.start = 1'b1; bus0.duration = 16'd10;
    step();
    bus0.start = 1'b0;
    check("abort_sig_0", {31'd0, bus0.signal}, 32'd1);
    for (int j = 1; j < 4; j++) begin
      step();
      check($sformatf("abort_sig_%0d", j), {31'd0, bus0.signal}, 32'd1);
    end
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    check("abort_sig_low", {31'd0, bus0.signal}, 32'd0);
    check("abort_busy", {31'd0, bus0.busy}, 32'd1);
    step();
    step();
    check("abort_guard_busy", {31'd0, bus0.busy}, 32'd1);
    check("abort_guard_done", {31'd0, bus0.done}, 32'd0);
    step();
    check("abort_done", {31'd0, bus0.done}, 32'd1);
    check("abort_done_busy", {31'd0, bus0.busy}, 32'd0);
    step();
    check("abort_done_once", {31'd0, bus0.done}, 32'd0);

    // reset mid-pulse
    bus0.start = 1'b1; bus0.duration = 16'd10;
    step();
    bus0.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("rst_mid_signal", {31'd0, bus0.signal}, 32'd0);
    check("rst_mid_busy", {31'd0, bus0.busy}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      if (bus0.done || bus0.signal) seen++;
    end
    check("rst_mid_no_activity", seen, 32'd0);

    // loopback width measurement
    measure(16'd7, 40);
    measure(16'hFFFF, 70000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
